// File: rtl/stream_rr_sched.sv
// Purpose  : round-robin burst scheduler; N requester streams share one registered output stream.
// Latency  : 1 cycle from input accept to otvalid; 1 idle arbitration cycle between grants.
// Backpres.: otready=0 with otvalid=1 drops itready[gnt]; the grant is kept and the beat count frozen.
//
// Ports
//   clk      clock, all logic on posedge
//   rstn     asynchronous active-low reset
//   itvalid  per-requester valid (N)
//   itready  per-requester ready, at most one bit high (N)
//   itdata   requester k data at [k*DW +: DW]
//   otvalid  output beat valid (registered)
//   otready  downstream ready
//   otdata   output beat data (registered)
//   otid     source index of the current output beat (registered)
module stream_rr_sched #(
    parameter  int N     = 2,
    parameter  int DEXP  = 0,
    parameter  int BURST = 16,
    localparam int DW    = 8 << DEXP,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    itvalid,
    output logic [N-1:0]    itready,
    input  logic [N*DW-1:0] itdata,
    output logic            otvalid,
    input  logic            otready,
    output logic [DW-1:0]   otdata,
    output logic [IW-1:0]   otid
);

    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   gnt_q;
    logic [CW-1:0]   cnt_q;
    logic            otvalid_q;
    logic [DW-1:0]   otdata_q;
    logic [IW-1:0]   otid_q;

    logic            out_free;
    logic            gnt_vld;
    logic            accept;
    logic            last_beat;
    logic            rel;
    logic [DW-1:0]   gnt_dat;
    logic [IW-1:0]   ptr_d;
    logic [IW-1:0]   arb_sel_d;
    logic            arb_found_d;

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free = ~otvalid_q | otready;

    // Ready is a function of registered state plus otready only, so there is
    // never a combinational path from any itvalid to any itready.
    always_comb begin
        itready = '0;
        if (state_q == S_GRANT) begin
            itready[gnt_q] = out_free;
        end
    end

    assign gnt_vld   = itvalid[gnt_q];
    assign accept    = (state_q == S_GRANT) & gnt_vld & out_free;
    assign last_beat = (cnt_q == CW'(BURST - 1));
    assign gnt_dat   = itdata[int'(gnt_q)*DW +: DW];

    // A granted source that drops valid gives up the rest of its burst.
    assign rel = (state_q == S_GRANT) & (~gnt_vld | (accept & last_beat));

    // Priority moves to the source after the one just served.
    assign ptr_d = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + 1'b1;

    // Rotating search: first valid requester at ptr, ptr+1, ... mod N.
    always_comb begin
        int idx;
        idx         = 0;
        arb_found_d = 1'b0;
        arb_sel_d   = ptr_q;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!arb_found_d && itvalid[idx]) begin
                arb_found_d = 1'b1;
                arb_sel_d   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            otvalid_q <= 1'b0;
            otdata_q  <= '0;
            otid_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Arbitration cycle: no beat is accepted here.
                    if (arb_found_d) begin
                        gnt_q   <= arb_sel_d;
                        cnt_q   <= '0;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Release on the last burst beat happens in the same cycle
                    // that beat is accepted.
                    if (rel) begin
                        ptr_q   <= ptr_d;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Load and drain in the same cycle keeps full throughput; a held
            // beat stays put until otready.
            if (accept) begin
                otvalid_q <= 1'b1;
                otdata_q  <= gnt_dat;
                otid_q    <= gnt_q;
            end else if (otready) begin
                otvalid_q <= 1'b0;
            end
        end
    end

    assign otvalid = otvalid_q;
    assign otdata  = otdata_q;
    assign otid    = otid_q;

endmodule

// File: tb/tb_stream_rr_sched.sv
// Purpose  : directed self-checking bench for stream_rr_sched (N=2/BURST=4 and N=3/BURST=16 instances).
// Latency  : checks sampled 1 time unit after each rising edge; handshakes sampled on the falling edge.
// Backpres.: otready is driven directly by the stimulus sequence.
module tb_stream_rr_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=2, BURST=4
    logic        rstn;
    logic [1:0]  itvalid_a;
    logic [1:0]  itready_a;
    logic [15:0] itdata_a;
    logic        otvalid_a;
    logic        otready_a;
    logic [7:0]  otdata_a;
    logic [0:0]  otid_a;

    // Instance B: N=3, BURST=16
    logic        rstn_b;
    logic [2:0]  itvalid_b;
    logic [2:0]  itready_b;
    logic [23:0] itdata_b;
    logic        otvalid_b;
    logic        otready_b;
    logic [7:0]  otdata_b;
    logic [1:0]  otid_b;

    // Source models: each source emits {src, seq} and advances seq on handshake.
    logic [5:0] seq_a [2];
    logic [5:0] exp_a [2];
    logic [7:0] seq_b;

    assign itdata_a = {2'b01, seq_a[1], 2'b00, seq_a[0]};
    assign itdata_b = {seq_b, 8'h11, 8'h22};

    int checks = 0;
    int fails  = 0;

    stream_rr_sched #(.N(2), .DEXP(0), .BURST(4)) u_a (
        .clk     (clk),
        .rstn    (rstn),
        .itvalid (itvalid_a),
        .itready (itready_a),
        .itdata  (itdata_a),
        .otvalid (otvalid_a),
        .otready (otready_a),
        .otdata  (otdata_a),
        .otid    (otid_a)
    );

    stream_rr_sched #(.N(3), .DEXP(0), .BURST(16)) u_b (
        .clk     (clk),
        .rstn    (rstn_b),
        .itvalid (itvalid_b),
        .itready (itready_b),
        .itdata  (itdata_b),
        .otvalid (otvalid_b),
        .otready (otready_b),
        .otdata  (otdata_b),
        .otid    (otid_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample handshakes mid-cycle, then advance sources after the edge.
    task automatic cyc();
        logic [1:0] hs_a;
        logic       hs_b;
        logic       sb_src;
        @(negedge clk);
        hs_a = itvalid_a & itready_a;
        hs_b = itvalid_b[2] & itready_b[2];
        if (otvalid_a && otready_a) begin
            // Beat leaves instance A: it must be the next in-order beat of its source.
            sb_src = otdata_a[6];
            chk("sb_id", 32'(otid_a), 32'(sb_src));
            chk("sb_dat", 32'(otdata_a), 32'({1'b0, sb_src, exp_a[sb_src]}));
            exp_a[sb_src] = exp_a[sb_src] + 6'd1;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (hs_a[k]) seq_a[k] = seq_a[k] + 6'd1;
        end
        if (hs_b) seq_b = seq_b + 8'd1;
    endtask

    task automatic clear_models();
        for (int k = 0; k < 2; k++) begin
            seq_a[k] = '0;
            exp_a[k] = '0;
        end
    endtask

    task automatic do_reset_a();
        rstn = 1'b0;
        clear_models();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        rstn_b    = 1'b0;
        itvalid_a = 2'b11;
        itvalid_b = 3'b000;
        otready_a = 1'b1;
        otready_b = 1'b1;
        seq_b     = '0;
        clear_models();
        repeat (2) @(posedge clk);
        #1;

        // Reset with all sources valid
        chk("rst_itready", 32'(itready_a), 32'd0);
        chk("rst_otvalid", 32'(otvalid_a), 32'd0);
        chk("rst_otid",    32'(otid_a),    32'd0);
        rstn = 1'b1;
        cyc();
        chk("first_grant", 32'(itready_a), 32'b01);

        // Both sources always valid: 4 beats src0, bubble, 4 beats src1, bubble, ...
        for (int c = 0; c < 15; c++) begin
            int pos;
            int b;
            cyc();
            pos = c % 5;
            b   = c / 5;
            if (pos == 4) begin
                chk("rr_bubble", 32'(otvalid_a), 32'd0);
            end else begin
                chk("rr_vld", 32'(otvalid_a), 32'd1);
                chk("rr_id",  32'(otid_a),    32'(b % 2));
                chk("rr_dat", 32'(otdata_a),  32'((b % 2) * 64 + (b / 2) * 4 + pos));
            end
        end

        // Backpressure mid-burst
        itvalid_a = 2'b01;
        do_reset_a();
        cyc();
        cyc();
        cyc();
        chk("bp_pre_dat", 32'(otdata_a), 32'd1);
        otready_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_itready", 32'(itready_a), 32'd0);
            chk("bp_vld",     32'(otvalid_a), 32'd1);
            chk("bp_dat",     32'(otdata_a),  32'd1);
            chk("bp_id",      32'(otid_a),    32'd0);
        end
        otready_a = 1'b1;
        cyc();
        chk("bp_resume2", 32'(otdata_a), 32'd2);
        cyc();
        chk("bp_resume3", 32'(otdata_a), 32'd3);
        cyc();
        chk("bp_burst_end", 32'(otvalid_a), 32'd0);

        // Early release: src0 drops valid after 2 beats
        itvalid_a = 2'b11;
        do_reset_a();
        cyc();
        chk("er_gnt0", 32'(itready_a), 32'b01);
        cyc();
        cyc();
        chk("er_dat1", 32'(otdata_a), 32'd1);
        itvalid_a = 2'b10;
        #1;
        chk("er_no_comb", 32'(itready_a), 32'b01);
        cyc();
        chk("er_idle_rdy", 32'(itready_a), 32'd0);
        chk("er_idle_vld", 32'(otvalid_a), 32'd0);
        cyc();
        chk("er_gnt1", 32'(itready_a), 32'b10);
        itvalid_a = 2'b11;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("er_s1_id",  32'(otid_a),   32'd1);
            chk("er_s1_dat", 32'(otdata_a), 32'(64 + i));
        end
        cyc();
        chk("er_regnt0", 32'(itready_a), 32'b01);
        chk("er_bubble", 32'(otvalid_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("er_s0_vld", 32'(otvalid_a), 32'd1);
            chk("er_s0_id",  32'(otid_a),    32'd0);
            chk("er_s0_dat", 32'(otdata_a),  32'(2 + i));
        end
        cyc();
        chk("er_s0_full", 32'(otvalid_a), 32'd0);

        // Async reset mid-burst of src1 (ptr=1 before reset)
        itvalid_a = 2'b11;
        do_reset_a();
        repeat (6) cyc();
        cyc();
        chk("ar_pre_vld", 32'(otvalid_a), 32'd1);
        chk("ar_pre_id",  32'(otid_a),    32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_vld",     32'(otvalid_a), 32'd0);
        chk("ar_itready", 32'(itready_a), 32'd0);
        chk("ar_id",      32'(otid_a),    32'd0);
        clear_models();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc();
        chk("ar_ptr0", 32'(itready_a), 32'b01);

        // N=3, BURST=16, only src2 valid
        itvalid_b = 3'b100;
        rstn_b    = 1'b1;
        cyc();
        chk("n3_gnt2", 32'(itready_b), 32'b100);
        for (int c = 0; c < 34; c++) begin
            int pos;
            cyc();
            pos = c % 17;
            if (pos == 16) begin
                chk("n3_bubble", 32'(otvalid_b), 32'd0);
            end else begin
                chk("n3_vld", 32'(otvalid_b), 32'd1);
                chk("n3_id",  32'(otid_b),    32'd2);
                chk("n3_dat", 32'(otdata_b),  32'((c / 17) * 16 + pos));
            end
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
